// File: rtl/msi_coherence_ctrl.sv
// msi_coherence_ctrl: per-cache MSI coherence controller for a snooping bus.
// Holds a direct-mapped state/tag array. CPU requests enter through a
// valid/ready handshake. Misses and upgrades go out as bus transactions
// through a request/grant handshake. Remote snoops are applied every cycle.
//
// Ports:
//   clock, reset_n            rising-edge clock, synchronous active-low reset
//   cpu_req_*                 CPU request (valid/ready, write flag, block address)
//   cpu_resp_valid/hit        one-cycle completion pulse; hit = no bus transaction
//   bus_req_*                 pending bus transaction (op 01 RdMiss, 10 WrMiss, 11 Inv)
//                             plus victim write-back flag and victim address
//   bus_grant                 arbiter completes the pending transaction this cycle
//   snoop_valid/op/addr       remote bus transaction
//   snoop_hit/writeback       registered snoop result (cycle after snoop_valid)
//   dbg_index/dbg_state       combinational observation of one line's state
module msi_coherence_ctrl #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned NUM_LINES  = 8,
    parameter int unsigned INDEX_W    = $clog2(NUM_LINES)
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_req_valid,
    input  logic                  cpu_req_write,
    input  logic [ADDR_WIDTH-1:0] cpu_req_addr,
    output logic                  cpu_req_ready,
    output logic                  cpu_resp_valid,
    output logic                  cpu_resp_hit,
    output logic                  bus_req_valid,
    output logic [1:0]            bus_req_op,
    output logic [ADDR_WIDTH-1:0] bus_req_addr,
    output logic                  bus_req_writeback,
    output logic [ADDR_WIDTH-1:0] bus_wb_addr,
    input  logic                  bus_grant,
    input  logic                  snoop_valid,
    input  logic [1:0]            snoop_op,
    input  logic [ADDR_WIDTH-1:0] snoop_addr,
    output logic                  snoop_hit,
    output logic                  snoop_writeback,
    input  logic [INDEX_W-1:0]    dbg_index,
    output logic [1:0]            dbg_state
);
    localparam int unsigned TAG_W = ADDR_WIDTH - INDEX_W;

    localparam logic [1:0] OP_RD  = 2'b01;
    localparam logic [1:0] OP_WR  = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    typedef enum logic [1:0] {LINE_I = 2'b00, LINE_S = 2'b01, LINE_M = 2'b10} line_t;
    typedef enum logic [1:0] {IDLE = 2'b00, BUS = 2'b01, RESP = 2'b10} fsm_t;

    line_t            line_state [NUM_LINES];
    logic [TAG_W-1:0] line_tag   [NUM_LINES];

    fsm_t state, state_next;
    logic armed;   // low until the first edge after reset is released

    logic [ADDR_WIDTH-1:0] req_addr;
    logic [1:0]            req_op;
    logic                  req_wb;
    logic [ADDR_WIDTH-1:0] req_wb_addr;
    logic                  resp_hit_q;
    logic                  snoop_hit_q;
    logic                  snoop_wb_q;

    // Snoop lookup against the current (pre-fill) array contents.
    logic [INDEX_W-1:0] snp_idx;
    logic [TAG_W-1:0]   snp_tag;
    line_t              snp_cur, snp_next;
    logic               snp_match, snp_wb;

    assign snp_idx   = snoop_addr[INDEX_W-1:0];
    assign snp_tag   = snoop_addr[ADDR_WIDTH-1:INDEX_W];
    assign snp_cur   = line_state[snp_idx];
    assign snp_match = snoop_valid && (snp_cur != LINE_I) && (line_tag[snp_idx] == snp_tag);

    always_comb begin
        snp_next = snp_cur;
        snp_wb   = 1'b0;
        if (snp_match) begin
            unique case (snoop_op)
                OP_RD: begin
                    if (snp_cur == LINE_M) begin
                        snp_next = LINE_S;
                        snp_wb   = 1'b1;
                    end
                end
                OP_WR: begin
                    snp_wb   = (snp_cur == LINE_M);
                    snp_next = LINE_I;
                end
                OP_INV:  snp_next = LINE_I;
                default: snp_next = snp_cur;
            endcase
        end
    end

    // CPU lookup sees the line as it will be after this cycle's snoop.
    logic [INDEX_W-1:0] cpu_idx;
    logic [TAG_W-1:0]   cpu_tag;
    line_t              cpu_cur;
    logic               cpu_match, cpu_done_local, accept;

    assign cpu_idx        = cpu_req_addr[INDEX_W-1:0];
    assign cpu_tag        = cpu_req_addr[ADDR_WIDTH-1:INDEX_W];
    assign cpu_cur        = (snp_match && snp_idx == cpu_idx) ? snp_next : line_state[cpu_idx];
    assign cpu_match      = (cpu_cur != LINE_I) && (line_tag[cpu_idx] == cpu_tag);
    assign cpu_done_local = cpu_match && (!cpu_req_write || cpu_cur == LINE_M);
    assign accept         = (state == IDLE) && armed && cpu_req_valid;

    logic [INDEX_W-1:0] req_idx;
    logic               grant_fire, req_line_snooped;

    assign req_idx          = req_addr[INDEX_W-1:0];
    assign grant_fire       = (state == BUS) && bus_grant;
    assign req_line_snooped = snp_match && (snp_idx == req_idx);

    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next        = state;
        cpu_req_ready     = 1'b0;
        cpu_resp_valid    = 1'b0;
        cpu_resp_hit      = 1'b0;
        bus_req_valid     = 1'b0;
        bus_req_op        = '0;
        bus_req_addr      = '0;
        bus_req_writeback = 1'b0;
        bus_wb_addr       = '0;
        unique case (state)
            IDLE: begin
                cpu_req_ready = armed;
                if (accept) state_next = cpu_done_local ? RESP : BUS;
            end
            BUS: begin
                bus_req_valid     = 1'b1;
                bus_req_op        = req_op;
                bus_req_addr      = req_addr;
                bus_req_writeback = req_wb;
                bus_wb_addr       = req_wb_addr;
                if (bus_grant) state_next = RESP;
            end
            RESP: begin
                cpu_resp_valid = 1'b1;
                cpu_resp_hit   = resp_hit_q;
                state_next     = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            armed       <= 1'b0;
            req_addr    <= '0;
            req_op      <= '0;
            req_wb      <= 1'b0;
            req_wb_addr <= '0;
            resp_hit_q  <= 1'b0;
            snoop_hit_q <= 1'b0;
            snoop_wb_q  <= 1'b0;
        end else begin
            armed       <= 1'b1;
            snoop_hit_q <= snp_match;
            snoop_wb_q  <= snp_wb;
            if (accept) begin
                req_addr    <= cpu_req_addr;
                resp_hit_q  <= cpu_done_local;
                req_op      <= !cpu_req_write ? OP_RD : (cpu_match ? OP_INV : OP_WR);
                req_wb      <= !cpu_match && (cpu_cur == LINE_M);
                req_wb_addr <= {line_tag[cpu_idx], cpu_idx};
            end else if (state == BUS && !bus_grant && req_line_snooped) begin
                // Lost the S copy while waiting to upgrade: now a full write miss.
                if (req_op == OP_INV && (snoop_op == OP_WR || snoop_op == OP_INV))
                    req_op <= OP_WR;
                // Victim left M through the snoop, so no write-back is owed.
                if (req_wb)
                    req_wb <= 1'b0;
            end
        end
    end

    // Fill is written after the snoop update so it wins on the same index.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < NUM_LINES; i++) begin
                line_state[i] <= LINE_I;
                line_tag[i]   <= '0;
            end
        end else begin
            if (snp_match) line_state[snp_idx] <= snp_next;
            if (grant_fire) begin
                if (req_op == OP_RD) line_state[req_idx] <= LINE_S;
                else                 line_state[req_idx] <= LINE_M;
                line_tag[req_idx] <= req_addr[ADDR_WIDTH-1:INDEX_W];
            end
        end
    end

    assign snoop_hit       = snoop_hit_q;
    assign snoop_writeback = snoop_wb_q;
    assign dbg_state       = line_state[dbg_index];

endmodule

// File: tb/tb_msi_coherence_ctrl.sv
// Directed bench for msi_coherence_ctrl with a line/transaction-level model.
module tb_msi_coherence_ctrl;
    logic        clock;
    logic        reset_n;
    logic        cpu_req_valid, cpu_req_write;
    logic [15:0] cpu_req_addr;
    logic        cpu_req_ready, cpu_resp_valid, cpu_resp_hit;
    logic        bus_req_valid;
    logic [1:0]  bus_req_op;
    logic [15:0] bus_req_addr;
    logic        bus_req_writeback;
    logic [15:0] bus_wb_addr;
    logic        bus_grant;
    logic        snoop_valid;
    logic [1:0]  snoop_op;
    logic [15:0] snoop_addr;
    logic        snoop_hit, snoop_writeback;
    logic [2:0]  dbg_index;
    logic [1:0]  dbg_state;

    msi_coherence_ctrl #(.ADDR_WIDTH(16), .NUM_LINES(8)) dut (
        .clock(clock), .reset_n(reset_n),
        .cpu_req_valid(cpu_req_valid), .cpu_req_write(cpu_req_write),
        .cpu_req_addr(cpu_req_addr), .cpu_req_ready(cpu_req_ready),
        .cpu_resp_valid(cpu_resp_valid), .cpu_resp_hit(cpu_resp_hit),
        .bus_req_valid(bus_req_valid), .bus_req_op(bus_req_op),
        .bus_req_addr(bus_req_addr), .bus_req_writeback(bus_req_writeback),
        .bus_wb_addr(bus_wb_addr), .bus_grant(bus_grant),
        .snoop_valid(snoop_valid), .snoop_op(snoop_op), .snoop_addr(snoop_addr),
        .snoop_hit(snoop_hit), .snoop_writeback(snoop_writeback),
        .dbg_index(dbg_index), .dbg_state(dbg_state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_pass   = 0;
    bit cmp_en   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        else
            n_pass++;
    endtask

    // Model: line states 0=I 1=S 2=M, tags, and the outstanding transaction.
    int m_st [8];
    int m_tg [8];
    bit m_armed, m_pend, m_resp_due, m_resp_hit;
    int m_op, m_addr, m_wb_addr;
    bit m_wb;
    bit e_snp_hit, e_snp_wb;

    task automatic model_step();
        int si, stg, ci, ctg, ri;
        bit shit, chit;
        if (!reset_n) begin
            for (int i = 0; i < 8; i++) begin m_st[i] = 0; m_tg[i] = 0; end
            m_armed = 0; m_pend = 0; m_resp_due = 0; m_resp_hit = 0;
            e_snp_hit = 0; e_snp_wb = 0;
            return;
        end
        si   = int'(snoop_addr) % 8;
        stg  = int'(snoop_addr) / 8;
        shit = snoop_valid && m_st[si] != 0 && m_tg[si] == stg;
        e_snp_hit = shit;
        e_snp_wb  = shit && m_st[si] == 2 && (snoop_op == 2'd1 || snoop_op == 2'd2);
        if (shit) begin
            if (snoop_op == 2'd1) begin
                if (m_st[si] == 2) m_st[si] = 1;
            end else if (snoop_op != 2'd0) begin
                m_st[si] = 0;
            end
        end
        if (m_resp_due) begin
            m_resp_due = 0;
        end else if (m_pend) begin
            ri = m_addr % 8;
            if (bus_grant) begin
                m_st[ri] = (m_op == 1) ? 1 : 2;
                m_tg[ri] = m_addr / 8;
                m_pend = 0; m_resp_due = 1; m_resp_hit = 0;
            end else if (shit && si == ri) begin
                if (m_op == 3 && (snoop_op == 2'd2 || snoop_op == 2'd3)) m_op = 2;
                m_wb = 0;
            end
        end else if (m_armed && cpu_req_valid) begin
            ci   = int'(cpu_req_addr) % 8;
            ctg  = int'(cpu_req_addr) / 8;
            chit = m_st[ci] != 0 && m_tg[ci] == ctg;
            if (chit && (!cpu_req_write || m_st[ci] == 2)) begin
                m_resp_due = 1; m_resp_hit = 1;
            end else begin
                m_pend    = 1;
                m_addr    = int'(cpu_req_addr);
                m_op      = !cpu_req_write ? 1 : (chit ? 3 : 2);
                m_wb      = !chit && m_st[ci] == 2;
                m_wb_addr = m_tg[ci] * 8 + ci;
            end
        end
        m_armed = 1;
    endtask

    always @(posedge clock) model_step();

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("ready", cpu_req_ready, m_armed && !m_pend && !m_resp_due);
            chk("resp_valid", cpu_resp_valid, m_resp_due);
            if (m_resp_due) chk("resp_hit", cpu_resp_hit, m_resp_hit);
            chk("bus_valid", bus_req_valid, m_pend);
            if (m_pend) begin
                chk("bus_op", bus_req_op, m_op);
                chk("bus_addr", bus_req_addr, m_addr);
                chk("bus_wb", bus_req_writeback, m_wb);
                if (m_wb) chk("bus_wb_addr", bus_wb_addr, m_wb_addr);
            end
            chk("snoop_hit", snoop_hit, e_snp_hit);
            chk("snoop_wb", snoop_writeback, e_snp_wb);
            chk("dbg_state", dbg_state, m_st[dbg_index]);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic cpu(input bit wr, input logic [15:0] a);
        cpu_req_valid = 1; cpu_req_write = wr; cpu_req_addr = a;
        tick();
        cpu_req_valid = 0;
    endtask

    task automatic snp(input logic [1:0] op, input logic [15:0] a);
        snoop_valid = 1; snoop_op = op; snoop_addr = a;
        tick();
        snoop_valid = 0;
    endtask

    task automatic grant();
        bus_grant = 1;
        tick();
        bus_grant = 0;
    endtask

    task automatic dbg(input string nm, input logic [2:0] idx, input logic [1:0] exp);
        dbg_index = idx;
        #1;
        chk(nm, dbg_state, exp);
    endtask

    initial begin
        reset_n = 0; cpu_req_valid = 0; cpu_req_write = 0; cpu_req_addr = '0;
        bus_grant = 0; snoop_valid = 0; snoop_op = '0; snoop_addr = '0; dbg_index = 3'd3;
        tick(); cmp_en = 1; tick();
        chk("lit_reset_ready", cpu_req_ready, 0);
        dbg("lit_reset_dbg", 3'd3, 2'b00);
        reset_n = 1; tick();
        chk("lit_ready_after_reset", cpu_req_ready, 1);

        // 1: read miss on 0x0013
        cpu(0, 16'h0013);
        chk("lit_rd_valid", bus_req_valid, 1);
        chk("lit_rd_op", bus_req_op, 2'b01);
        chk("lit_rd_addr", bus_req_addr, 16'h0013);
        chk("lit_rd_wb", bus_req_writeback, 0);
        tick();
        grant();
        chk("lit_rd_resp", cpu_resp_valid, 1);
        chk("lit_rd_resp_hit", cpu_resp_hit, 0);
        dbg("lit_rd_state_S", 3'd3, 2'b01);
        tick();
        chk("lit_ready_again", cpu_req_ready, 1);

        // 2: upgrade then read hit
        cpu(1, 16'h0013);
        chk("lit_upg_op", bus_req_op, 2'b11);
        grant();
        dbg("lit_upg_state_M", 3'd3, 2'b10);
        tick();
        cpu(0, 16'h0013);
        chk("lit_hit_resp", cpu_resp_valid, 1);
        chk("lit_hit_flag", cpu_resp_hit, 1);
        chk("lit_hit_no_bus", bus_req_valid, 0);
        tick();

        // 3: conflict miss evicting the M victim
        cpu(0, 16'h0023);
        chk("lit_evict_op", bus_req_op, 2'b01);
        chk("lit_evict_wb", bus_req_writeback, 1);
        chk("lit_evict_wb_addr", bus_wb_addr, 16'h0013);
        grant();
        dbg("lit_evict_state_S", 3'd3, 2'b01);
        tick();

        // 4: snoops on an M line
        cpu(1, 16'h0013);
        chk("lit_wrmiss_op", bus_req_op, 2'b10);
        grant(); tick();
        snp(2'b01, 16'h0013);
        chk("lit_snp_rd_hit", snoop_hit, 1);
        chk("lit_snp_rd_wb", snoop_writeback, 1);
        dbg("lit_snp_rd_state", 3'd3, 2'b01);
        snp(2'b10, 16'h0013);
        chk("lit_snp_wr_hit", snoop_hit, 1);
        chk("lit_snp_wr_wb", snoop_writeback, 0);
        dbg("lit_snp_wr_state", 3'd3, 2'b00);

        // 5: pending upgrade killed by an invalidate
        cpu(0, 16'h0013); grant(); tick();
        cpu(1, 16'h0013); tick();
        snp(2'b11, 16'h0013);
        dbg("lit_upg_inv_state", 3'd3, 2'b00);
        chk("lit_upg_conv_op", bus_req_op, 2'b10);
        grant();
        chk("lit_upg_conv_hit", cpu_resp_hit, 0);
        dbg("lit_upg_conv_M", 3'd3, 2'b10);
        tick();

        // Victim supplied by a snoop while its write-back is pending
        cpu(0, 16'h0023);
        chk("lit_vic_wb_before", bus_req_writeback, 1);
        snp(2'b01, 16'h0013);
        chk("lit_vic_wb_after", bus_req_writeback, 0);
        chk("lit_vic_snp_wb", snoop_writeback, 1);
        grant(); tick();

        // Snoop and grant on the same index in the same cycle: fill wins
        cpu(1, 16'h0033);
        snoop_valid = 1; snoop_op = 2'b10; snoop_addr = 16'h0023; bus_grant = 1;
        tick();
        snoop_valid = 0; bus_grant = 0;
        chk("lit_fill_snp_hit", snoop_hit, 1);
        dbg("lit_fill_wins", 3'd3, 2'b10);
        tick();

        // Snoop and CPU lookup on the same index: lookup sees post-snoop line
        cpu_req_valid = 1; cpu_req_write = 0; cpu_req_addr = 16'h0033;
        snoop_valid = 1; snoop_op = 2'b10; snoop_addr = 16'h0033;
        tick();
        cpu_req_valid = 0; snoop_valid = 0;
        chk("lit_race_miss", bus_req_valid, 1);
        chk("lit_race_no_wb", bus_req_writeback, 0);
        chk("lit_race_snp_wb", snoop_writeback, 1);
        grant(); tick();

        // Highest index
        cpu(0, 16'hFFFF); grant();
        dbg("lit_idx7_S", 3'd7, 2'b01);
        tick();

        // 6: reset while a transaction is on the bus
        cpu(1, 16'h0045);
        chk("lit_pre_rst_bus", bus_req_valid, 1);
        reset_n = 0; tick();
        chk("lit_rst_bus", bus_req_valid, 0);
        chk("lit_rst_ready", cpu_req_ready, 0);
        chk("lit_rst_resp", cpu_resp_valid, 0);
        dbg("lit_rst_line3", 3'd3, 2'b00);
        dbg("lit_rst_line7", 3'd7, 2'b00);
        tick(); reset_n = 1; tick(); tick();
        chk("lit_rst_no_resp", cpu_resp_valid, 0);
        chk("lit_rst_ready_back", cpu_req_ready, 1);
        tick(); tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
